// File: rtl/impulse_seq_ctrl_pkg.sv
// Shared definitions for the impulse sequencer: default widths and FSM states.
package impulse_seq_ctrl_pkg;

  localparam int unsigned DEF_DATA_W = 18;
  localparam int unsigned DEF_CNT_W  = 9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_FIRE    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

endpackage

// File: rtl/impulse_seq_ctrl_seq_counter.sv
// Up-counter with synchronous clear, saturation at all-ones and an equality
// compare against an external value. Used for both delay and capture counts.
module seq_counter #(
  parameter int unsigned W = 9
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_cmp,
  output logic [W-1:0] o_cnt,
  output logic         o_eq
);

  logic [W-1:0] r_cnt;

  // Count register: clear wins over enable; hold once saturated.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_eq  = (r_cnt == i_cmp);

endmodule

// File: rtl/impulse_seq_ctrl.sv
// Impulse sequencer: waits a programmable number of sample ticks, drives a
// one-sample-period impulse into a filter, then captures its response.
module impulse_seq_ctrl
  import impulse_seq_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic                     sys_clk,
  input  logic                     reset,
  input  logic                     sam_clk_en,
  input  logic                     sym_clk_en,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     align_sym,
  input  logic [CNT_W-1:0]         pre_delay,
  input  logic [CNT_W-1:0]         cap_len,
  input  logic signed [DATA_W-1:0] symbol,
  input  logic signed [DATA_W-1:0] response,
  output logic signed [DATA_W-1:0] stimulus,
  output logic                     cap_valid,
  output logic signed [DATA_W-1:0] cap_data,
  output logic [CNT_W-1:0]         cap_idx,
  output logic                     busy,
  output logic                     done
);

  state_t r_state, w_next_state;

  logic [CNT_W-1:0]         r_pre_delay, r_cap_len;
  logic signed [DATA_W-1:0] r_symbol;
  logic                     r_align;

  logic signed [DATA_W-1:0] r_stim, w_stim;
  logic                     r_cap_valid, w_cap_valid;
  logic signed [DATA_W-1:0] r_cap_data, w_cap_data;
  logic [CNT_W-1:0]         r_cap_idx, w_cap_idx;
  logic                     r_done, w_done;

  logic                     w_latch;
  logic                     w_dly_en, w_dly_clr, w_dly_eq;
  logic                     w_cap_en, w_cap_clr, w_cap_eq;
  logic [CNT_W-1:0]         w_dly_cnt, w_cap_cnt, w_cap_last;

  // Only evaluated in CAPTURE, where the latched length is non-zero.
  assign w_cap_last = r_cap_len - CNT_W'(1);

  seq_counter #(.W(CNT_W)) u_dly_cnt (
    .i_clk   (sys_clk),
    .i_reset (reset),
    .i_en    (w_dly_en),
    .i_clr   (w_dly_clr),
    .i_cmp   (r_pre_delay),
    .o_cnt   (w_dly_cnt),
    .o_eq    (w_dly_eq)
  );

  seq_counter #(.W(CNT_W)) u_cap_cnt (
    .i_clk   (sys_clk),
    .i_reset (reset),
    .i_en    (w_cap_en),
    .i_clr   (w_cap_clr),
    .i_cmp   (w_cap_last),
    .o_cnt   (w_cap_cnt),
    .o_eq    (w_cap_eq)
  );

  // State register.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next state, counter controls and next output values; abort overrides all.
  always_comb begin
    w_next_state = r_state;
    w_stim       = r_stim;
    w_cap_valid  = 1'b0;
    w_cap_data   = r_cap_data;
    w_cap_idx    = r_cap_idx;
    w_done       = 1'b0;
    w_latch      = 1'b0;
    w_dly_en     = 1'b0;
    w_dly_clr    = 1'b0;
    w_cap_en     = 1'b0;
    w_cap_clr    = 1'b0;
    if ((r_state != ST_IDLE) && abort) begin
      w_next_state = ST_IDLE;
      w_stim       = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_stim = '0;
          if (start && !abort) begin
            w_latch      = 1'b1;
            w_dly_clr    = 1'b1;
            w_cap_clr    = 1'b1;
            w_next_state = ST_ARM;
          end
        end
        ST_ARM: begin
          if (sam_clk_en) begin
            if (!w_dly_eq) begin
              w_dly_en = (w_dly_cnt != '1);
            end else if (!r_align || sym_clk_en) begin
              w_stim       = r_symbol;
              w_next_state = ST_FIRE;
            end
          end
        end
        ST_FIRE: begin
          if (sam_clk_en) begin
            w_stim = '0;
            if (r_cap_len == '0) begin
              w_done       = 1'b1;
              w_next_state = ST_IDLE;
            end else begin
              w_cap_clr    = 1'b1;
              w_next_state = ST_CAPTURE;
            end
          end
        end
        ST_CAPTURE: begin
          if (sam_clk_en) begin
            w_cap_valid = 1'b1;
            w_cap_data  = response;
            w_cap_idx   = w_cap_cnt;
            w_cap_en    = 1'b1;
            if (w_cap_eq) begin
              w_done       = 1'b1;
              w_next_state = ST_IDLE;
            end
          end
        end
        default: begin
          w_stim       = '0;
          w_next_state = ST_IDLE;
        end
      endcase
    end
  end

  // Registered outputs and per-sequence configuration latched on start.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_stim      <= '0;
      r_cap_valid <= 1'b0;
      r_cap_data  <= '0;
      r_cap_idx   <= '0;
      r_done      <= 1'b0;
      r_pre_delay <= '0;
      r_cap_len   <= '0;
      r_symbol    <= '0;
      r_align     <= 1'b0;
    end else begin
      r_stim      <= w_stim;
      r_cap_valid <= w_cap_valid;
      r_cap_data  <= w_cap_data;
      r_cap_idx   <= w_cap_idx;
      r_done      <= w_done;
      if (w_latch) begin
        r_pre_delay <= pre_delay;
        r_cap_len   <= cap_len;
        r_symbol    <= symbol;
        r_align     <= align_sym;
      end
    end
  end

  assign stimulus  = r_stim;
  assign cap_valid = r_cap_valid;
  assign cap_data  = r_cap_data;
  assign cap_idx   = r_cap_idx;
  assign done      = r_done;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_impulse_seq_ctrl.sv
// Bench for impulse_seq_ctrl: fixed vector table, hand-written corner
// sequences and randomized runs checked against a tick-list model.
module tb_impulse_seq_ctrl;

  localparam int DW = 18;
  localparam int CW = 9;

  logic                 sys_clk = 1'b0;
  logic                 reset, sam_clk_en, sym_clk_en, start, abort, align_sym;
  logic [CW-1:0]        pre_delay, cap_len, cap_idx;
  logic signed [DW-1:0] symbol, response, stimulus, cap_data;
  logic                 cap_valid, busy, done;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  impulse_seq_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .sam_clk_en (sam_clk_en),
    .sym_clk_en (sym_clk_en),
    .start      (start),
    .abort      (abort),
    .align_sym  (align_sym),
    .pre_delay  (pre_delay),
    .cap_len    (cap_len),
    .symbol     (symbol),
    .response   (response),
    .stimulus   (stimulus),
    .cap_valid  (cap_valid),
    .cap_data   (cap_data),
    .cap_idx    (cap_idx),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    int pd; int len; int sym; int al; int ph; int p;
    int e_fire; int e_done; int e_ncap; int e_width;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic quiet_inputs();
    sam_clk_en = 0; sym_clk_en = 0; start = 0; abort = 0; align_sym = 0;
    pre_delay = '0; cap_len = '0; symbol = '0; response = '0;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Regular sample grid (every p cycles); symbol tick on every 4th sample at phase ph.
  task automatic run_vec(input vec_t v, input int n);
    int fire_c, done_c, width, ncap, bad_val, bad_idx, bad_data, extra_done, idx_at_done, val_at_done;
    logic signed [DW-1:0] r;
    fire_c = -1; done_c = -1; width = 0; ncap = 0; bad_val = 0; bad_idx = 0;
    bad_data = 0; extra_done = 0; idx_at_done = -1; val_at_done = 0;
    for (int c = 0; c < 400 && (done_c < 0 || c <= done_c + 3); c++) begin
      if (c == 0) begin
        pre_delay = CW'(v.pd); cap_len = CW'(v.len); symbol = DW'(v.sym);
        align_sym = (v.al != 0); start = 1;
      end else begin
        pre_delay = CW'($urandom_range(0, 511)); cap_len = CW'($urandom_range(0, 511));
        symbol = DW'($urandom); align_sym = $urandom_range(0, 1) != 0;
        start = (c == 2);
      end
      sam_clk_en = (c > 0) && (c % v.p == 0);
      sym_clk_en = sam_clk_en && ((c / v.p) % 4 == v.ph);
      r = DW'(c * 37 - 500);
      response = r;
      tick();
      if (stimulus != 0) begin
        if (fire_c < 0) fire_c = c;
        width++;
        if (int'(stimulus) != v.sym) bad_val++;
      end
      if (cap_valid) begin
        if (int'(cap_idx) != ncap) bad_idx++;
        if (cap_data != r) bad_data++;
        ncap++;
      end
      if (done) begin
        if (done_c < 0) begin
          done_c = c; idx_at_done = int'(cap_idx); val_at_done = int'(cap_valid);
        end else extra_done++;
      end
    end
    start = 0; sam_clk_en = 0; sym_clk_en = 0;
    chk($sformatf("v%0d_fire_cycle", n), fire_c, v.e_fire);
    chk($sformatf("v%0d_imp_width", n), width, v.e_width);
    chk($sformatf("v%0d_imp_value", n), bad_val, 0);
    chk($sformatf("v%0d_done_cycle", n), done_c, v.e_done);
    chk($sformatf("v%0d_ncap", n), ncap, v.e_ncap);
    chk($sformatf("v%0d_idx_seq", n), bad_idx, 0);
    chk($sformatf("v%0d_cap_data", n), bad_data, 0);
    chk($sformatf("v%0d_extra_done", n), extra_done, 0);
    chk($sformatf("v%0d_busy_end", n), busy, 0);
    if (v.len > 0) begin
      chk($sformatf("v%0d_done_idx", n), idx_at_done, v.len - 1);
      chk($sformatf("v%0d_done_valid", n), val_at_done, 1);
    end
  endtask

  // Random run. Model: list the sample ticks after start; the impulse
  // starts on the first tick numbered >= pre_delay+1 that meets alignment,
  // ends on the next tick, and each following tick captures one sample.
  task automatic run_random(input int n);
    bit s[256], y[256], st[256], ev[256];
    int ei[256];
    logic signed [DW-1:0] rsp[256];
    int pd, len, al, ph, ticks, f, g, k, e_end;
    logic signed [DW-1:0] sv, es;
    pd = $urandom_range(0, 15); len = $urandom_range(0, 10);
    al = $urandom_range(0, 1); ph = $urandom_range(0, 3);
    sv = DW'($urandom);
    ticks = 0;
    for (int c = 0; c < 256; c++) begin
      s[c] = (c > 0) && ($urandom_range(0, 2) != 0);
      y[c] = 0;
      if (s[c]) begin
        ticks++;
        y[c] = (ticks % 4 == ph);
      end
      rsp[c] = DW'($urandom);
      ev[c] = 0; ei[c] = 0;
    end
    ticks = 0; f = -1; g = -1; e_end = -1; k = 0;
    for (int c = 1; c < 256; c++) begin
      if (s[c]) begin
        ticks++;
        if (f < 0) begin
          if (ticks >= pd + 1 && (al == 0 || y[c])) f = c;
        end else if (g < 0) begin
          g = c;
          if (len == 0) e_end = c;
        end else if (k < len) begin
          ev[c] = 1; ei[c] = k; k++;
          if (k == len) e_end = c;
        end
      end
    end
    if (e_end < 0 || e_end > 250) begin
      checks++; errors++;
      $display("FAIL r%0d_model_budget: got end %0d required below 251", n, e_end);
      return;
    end
    for (int c = 0; c < 256; c++) st[c] = (c == 0) || (c < e_end && $urandom_range(0, 7) == 0);
    for (int c = 0; c <= e_end + 3; c++) begin
      start = st[c]; sam_clk_en = s[c]; sym_clk_en = y[c]; response = rsp[c];
      if (c == 0) begin
        pre_delay = CW'(pd); cap_len = CW'(len); symbol = sv; align_sym = (al != 0);
      end else begin
        pre_delay = CW'($urandom); cap_len = CW'($urandom); symbol = DW'($urandom);
        align_sym = $urandom_range(0, 1) != 0;
      end
      tick();
      es = (c >= f && c < g) ? sv : '0;
      chk($sformatf("r%0d_c%0d_stim", n, c), longint'(stimulus), longint'(es));
      chk($sformatf("r%0d_c%0d_busy", n, c), busy, (c < e_end) ? 1 : 0);
      chk($sformatf("r%0d_c%0d_done", n, c), done, (c == e_end) ? 1 : 0);
      chk($sformatf("r%0d_c%0d_valid", n, c), cap_valid, ev[c] ? 1 : 0);
      if (ev[c]) begin
        chk($sformatf("r%0d_c%0d_data", n, c), longint'(cap_data), longint'(rsp[c]));
        chk($sformatf("r%0d_c%0d_idx", n, c), cap_idx, ei[c]);
      end
    end
    quiet_inputs();
  endtask

  initial begin
    int found, nv, nd;
    tbl[0] = '{0, 3, 100, 0, 0, 1, 1, 5, 3, 1};
    tbl[1] = '{3, 2, -5, 0, 0, 2, 8, 14, 2, 2};
    tbl[2] = '{2, 4, 300, 1, 1, 1, 5, 10, 4, 1};
    tbl[3] = '{5, 0, -77, 0, 0, 3, 18, 21, 0, 3};
    tbl[4] = '{29, 64, 49152, 0, 0, 2, 60, 190, 64, 2};
    tbl[5] = '{4, 1, 1000, 1, 0, 2, 16, 20, 1, 2};

    quiet_inputs();
    reset = 1;
    #23;
    chk("rst_stim", longint'(stimulus), 0);
    chk("rst_valid", cap_valid, 0);
    chk("rst_data", longint'(cap_data), 0);
    chk("rst_idx", cap_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge sys_clk);
    reset = 0;
    tick();

    // start together with abort in IDLE is ignored
    start = 1; abort = 1; pre_delay = 1; cap_len = 2; symbol = 9;
    tick();
    start = 0; abort = 0;
    chk("start_abort_idle_busy", busy, 0);
    tick();
    chk("start_abort_idle_busy2", busy, 0);

    for (int i = 0; i < 6; i++) run_vec(tbl[i], i);

    // abort at cap_idx 10, sampled together with a sample tick
    pre_delay = 1; cap_len = 20; symbol = 7; align_sym = 0; start = 1; sam_clk_en = 1;
    found = 0;
    for (int c = 0; c < 100 && found == 0; c++) begin
      response = DW'(c);
      tick();
      start = 0;
      if (cap_valid && cap_idx == 10) found = 1;
    end
    chk("abort_reach_idx10", found, 1);
    abort = 1;
    tick();
    abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", cap_valid, 0);
    chk("abort_done", done, 0);
    chk("abort_stim", longint'(stimulus), 0);
    nv = 0; nd = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      nv += int'(cap_valid); nd += int'(done);
    end
    chk("abort_after_valid", nv, 0);
    chk("abort_after_done", nd, 0);
    sam_clk_en = 0;
    run_vec(tbl[0], 10);

    // reset while the impulse is on the wire
    pre_delay = 2; cap_len = 5; symbol = 123; align_sym = 0; start = 1; sam_clk_en = 1;
    found = 0;
    for (int c = 0; c < 50 && found == 0; c++) begin
      tick();
      start = 0;
      if (stimulus != 0) found = 1;
    end
    chk("fire_reached", found, 1);
    #2 reset = 1;
    #1;
    chk("rst_fire_stim", longint'(stimulus), 0);
    chk("rst_fire_busy", busy, 0);
    chk("rst_fire_valid", cap_valid, 0);
    chk("rst_fire_done", done, 0);
    chk("rst_fire_data", longint'(cap_data), 0);
    chk("rst_fire_idx", cap_idx, 0);
    @(negedge sys_clk);
    reset = 0;
    nv = 0; nd = 0; found = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      nv += int'(cap_valid); nd += int'(done); found += int'(busy);
    end
    chk("rst_after_valid", nv, 0);
    chk("rst_after_done", nd, 0);
    chk("rst_after_busy", found, 0);
    quiet_inputs();
    tick();

    for (int i = 0; i < 30; i++) run_random(i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/impulse_seq_ctrl.md
IMPULSE_SEQ_CTRL -- requirements
Module: impulse_seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 18, sample/stimulus width (signed).
REQ-002 SHALL have parameter CNT_W, default 9, width of delay/length/index counters.
REQ-003 SHALL have port sys_clk  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port sam_clk_en  input  1  one-sys_clk sample-rate enable.
REQ-006 SHALL have port sym_clk_en  input  1  one-sys_clk symbol-rate enable, coincident with a sam_clk_en.
REQ-007 SHALL have port start  input  1  one-cycle request to run one impulse sequence.
REQ-008 SHALL have port abort  input  1  terminate the running sequence.
REQ-009 SHALL have port align_sym  input  1  when 1, impulse fires only on a sym_clk_en tick.
REQ-010 SHALL have port pre_delay  input  CNT_W  number of sam_clk_en ticks before the impulse.
REQ-011 SHALL have port cap_len  input  CNT_W  number of response samples to capture.
REQ-012 SHALL have port symbol  input  DATA_W  signed impulse amplitude.
REQ-013 SHALL have port response  input  DATA_W  signed filter output under test.
REQ-014 SHALL have port stimulus  output  DATA_W  signed, registered drive to the filter input.
REQ-015 SHALL have port cap_valid  output  1  one-cycle strobe, cap_data/cap_idx valid.
REQ-016 SHALL have port cap_data  output  DATA_W  captured response sample.
REQ-017 SHALL have port cap_idx  output  CNT_W  capture index, 0 = first captured sample.
REQ-018 SHALL have port busy  output  1  high in every state except IDLE.
REQ-019 SHALL have port done  output  1  one-cycle strobe on normal completion (not on abort).

Function
REQ-020 SHALL implement FSM states IDLE, ARM, FIRE, CAPTURE.
REQ-021 SHALL latch pre_delay, cap_len, symbol, align_sym on start in IDLE; move to ARM; delay counter cleared to 0.
REQ-022 SHALL ignore start when not in IDLE.
REQ-023 ARM: each sam_clk_en with counter != pre_delay increments the counter (saturates at all-ones).
REQ-024 ARM: on a sam_clk_en with counter == pre_delay (and sym_clk_en if align_sym latched) -> stimulus <= symbol next edge, state FIRE; if alignment is not met, hold the counter and wait.
REQ-025 FIRE: stimulus held at symbol until the next sam_clk_en; on that tick stimulus <= 0 and state CAPTURE, capture counter 0; if cap_len == 0 -> IDLE with done instead.
REQ-026 CAPTURE: on each sam_clk_en register cap_data <= response, cap_idx <= capture counter, cap_valid = 1 for exactly one cycle, counter increments.
REQ-027 CAPTURE: on the tick producing cap_idx == cap_len-1 -> done strobe coincident with that cap_valid, state IDLE.
REQ-028 stimulus SHALL be 0 in every state except FIRE; impulse width = exactly one sample period.
REQ-029 abort (any non-IDLE state) SHALL force IDLE, stimulus 0, no cap_valid, no done, on the next edge; abort has priority over sam_clk_en in the same cycle.
REQ-030 sam_clk_en low cycles SHALL cause no state, counter or output change (except strobe deassertion).
REQ-031 start and abort both high in IDLE SHALL be ignored (remain IDLE).

Reset
REQ-032 reset SHALL force IDLE, all counters 0, stimulus 0, cap_data 0, cap_idx 0, cap_valid 0, busy 0, done 0.
REQ-033 reset asserted mid-sequence SHALL discard the sequence; no done after release.

Structure
REQ-034 State encoding and DATA_W/CNT_W defaults SHALL live in the shared defines header.
REQ-035 One sub-module, seq_counter (enable, clear, compare-equal, saturate), SHALL be instantiated for both delay and capture counters.

Verification
REQ-036 pre_delay=29, cap_len=64, symbol=49152, align_sym=0 -> stimulus=49152 for one sample period after the 30th sam_clk_en; 64 cap_valid, cap_idx 0..63, done with idx 63.
REQ-037 With real filter attached, REQ-036 run -> captured samples match the filter's golden impulse response bit-exact.
REQ-038 align_sym=1, pre_delay=2, sym_clk_en every 4th sam_clk_en, phase offset 1 -> impulse fires on first sym_clk_en at counter==2, not before.
REQ-039 cap_len=0 -> one-period impulse, zero cap_valid, done 1 cycle after impulse end; start during busy -> no effect.
REQ-040 abort at cap_idx=10 -> IDLE next edge, no further cap_valid, no done; new start then runs cleanly.
REQ-041 reset asserted during FIRE -> stimulus 0 immediately, all outputs at reset values, busy 0.
